fpu_arbiter: RTL

- Shares one instance of the combinational `fpu` datapath between NUM_REQ requesters, e.g. shader lanes or the rasteriser setup unit.
- Each requester presents operands and an FPUctrl opcode with a valid/ready handshake.
- The block arbitrates round-robin, registers the operands, drives the fpu, and returns a registered result tagged with the requester index on a single backpressured response channel.

---
 rtl/fpu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one combinational fpu between NUM_REQ requesters.
// Each requester uses a valid/ready handshake. A grant latches that requester's
// operands, the fpu evaluates them for one cycle, and the result is returned
// on a single backpressured response channel tagged with the requester index.

// Combinational single-precision style fpu.
// Opcodes: 000 add, 001 sub, 010 mul, 011 min, 100 max, 101 abs, 110 neg,
// 111 unsupported (returns 0).
// Arithmetic rounds to nearest-even on the retained guard bits.
// Subnormal operands are flushed to zero. Underflow flushes to a signed zero
// and overflow saturates to infinity. Any inf/NaN operand to add, sub or mul
// yields the canonical quiet NaN. Min and max compare sign-magnitude values.
module fpu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);
    localparam int EW   = 8;
    localparam int MW   = WIDTH - 1 - EW;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;
    localparam int XW   = MW + 5;   // carry + hidden + fraction + 3 guard bits

    logic          sa, sb, sb_eff;
    logic [EW-1:0] ea, eb;
    logic          a_zero, b_zero, a_special, b_special;
    logic [MW:0]   ma, mb;
    logic [WIDTH-2:0] a_mag, b_mag;
    logic [WIDTH-1:0] qnan;

    assign sa        = a[WIDTH-1];
    assign sb        = b[WIDTH-1];
    assign ea        = a[WIDTH-2:MW];
    assign eb        = b[WIDTH-2:MW];
    assign a_mag     = a[WIDTH-2:0];
    assign b_mag     = b[WIDTH-2:0];
    assign a_zero    = (ea == '0);
    assign b_zero    = (eb == '0);
    assign a_special = (ea == EW'(EMAX));
    assign b_special = (eb == EW'(EMAX));
    assign ma        = a_zero ? '0 : {1'b1, a[MW-1:0]};
    assign mb        = b_zero ? '0 : {1'b1, b[MW-1:0]};
    assign sb_eff    = sb ^ (op == 3'b001);
    assign qnan      = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    // Range-check a rounded {exponent, fraction} pair and pack the result.
    function automatic logic [WIDTH-1:0] pack_result(
        input logic            sign,
        input logic            nonzero,
        input logic [EW+MW+1:0] ext
    );
        logic [EW+1:0] e;
        e = ext[EW+MW+1:MW];
        if (!nonzero || e[EW+1] || (e == '0))
            return {sign, {(WIDTH-1){1'b0}}};
        if (e >= (EW+2)'(EMAX))
            return {sign, {EW{1'b1}}, {MW{1'b0}}};
        return {sign, e[EW-1:0], ext[MW-1:0]};
    endfunction

    // ---------------- add / sub ----------------
    logic          swap, big_s, eff_sub;
    logic [EW-1:0] big_e, sml_e, exp_diff;
    logic [MW:0]   big_m, sml_m;
    logic [XW-1:0] big_x, sml_x, sum;
    logic [5:0]    lz;
    logic [XW-2:0] norm;
    logic [EW+1:0] add_e;
    logic          add_round;
    logic [EW+MW+1:0] add_ext;
    logic [WIDTH-1:0] add_res;

    // Align the smaller operand, add or subtract magnitudes, renormalise and round.
    always_comb begin
        swap     = (b_mag > a_mag);
        big_s    = swap ? sb_eff : sa;
        big_e    = swap ? eb : ea;
        sml_e    = swap ? ea : eb;
        big_m    = swap ? mb : ma;
        sml_m    = swap ? ma : mb;
        eff_sub  = sa ^ sb_eff;
        exp_diff = big_e - sml_e;
        big_x    = {1'b0, big_m, 3'b000};
        sml_x    = {1'b0, sml_m, 3'b000} >> exp_diff;
        sum      = eff_sub ? (big_x - sml_x) : (big_x + sml_x);
        lz       = '0;
        for (int i = 0; i < XW - 1; i++) begin
            if (sum[i]) lz = 6'(XW - 2 - i);
        end
        add_e = {2'b00, big_e};
        if (sum[XW-1]) begin
            norm  = {sum[XW-1:2], sum[1] | sum[0]};
            add_e = add_e + 1'b1;
        end else begin
            norm  = sum[XW-2:0] << lz;
            add_e = add_e - {{(EW-4){1'b0}}, lz};
        end
        add_round = norm[2] & (norm[1] | norm[0] | norm[3]);
        add_ext   = {add_e, norm[XW-3:3]} + (EW+MW+2)'(add_round);
        // An exact cancellation gives +0; only -0 + -0 keeps the negative sign.
        if (!norm[XW-2])
            add_res = pack_result(sa & sb_eff, 1'b0, add_ext);
        else
            add_res = pack_result(big_s, 1'b1, add_ext);
    end

    // ---------------- mul ----------------
    logic [2*MW+1:0] prod, prod_n;
    logic [EW+1:0]   mul_e;
    logic            mul_round;
    logic [EW+MW+1:0] mul_ext;
    logic [WIDTH-1:0] mul_res;

    // Multiply significands, normalise by at most one bit, round and repack.
    always_comb begin
        prod  = {{(MW+1){1'b0}}, ma} * {{(MW+1){1'b0}}, mb};
        mul_e = {2'b00, ea} + {2'b00, eb} - (EW+2)'(BIAS);
        if (prod[2*MW+1]) begin
            prod_n = prod;
            mul_e  = mul_e + 1'b1;
        end else begin
            prod_n = prod << 1;
        end
        mul_round = prod_n[MW] & ((|prod_n[MW-1:0]) | prod_n[MW+1]);
        mul_ext   = {mul_e, prod_n[2*MW:MW+1]} + (EW+MW+2)'(mul_round);
        mul_res   = pack_result(sa ^ sb, prod_n[2*MW+1], mul_ext);
    end

    // ---------------- compare + result select ----------------
    logic a_lt_b;

    // Pick the result for the requested opcode.
    always_comb begin
        if (sa != sb)
            a_lt_b = sa;
        else if (!sa)
            a_lt_b = (a_mag < b_mag);
        else
            a_lt_b = (a_mag > b_mag);

        y = '0;
        case (op)
            3'b000, 3'b001: y = (a_special | b_special) ? qnan : add_res;
            3'b010:         y = (a_special | b_special) ? qnan : mul_res;
            3'b011:         y = a_lt_b ? a : b;
            3'b100:         y = a_lt_b ? b : a;
            3'b101:         y = {1'b0, a_mag};
            3'b110:         y = {~sa, a_mag};
            default:        y = '0;
        endcase
    end
endmodule

module fpu_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [15:0]              op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ID_W-1:0]  rr_ptr_reg;
    logic [WIDTH-1:0] opa_reg, opb_reg;
    logic [2:0]       opc_reg;
    logic [ID_W-1:0]  id_reg;
    logic             rsp_valid_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_err_reg;
    logic [15:0]      op_count_reg;

    logic             grant_any, grant_allowed, grant_fire;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] fpu_y;

    logic [WIDTH-1:0] a_arr  [NUM_REQ];
    logic [WIDTH-1:0] b_arr  [NUM_REQ];
    logic [2:0]       op_arr [NUM_REQ];

    // Unpack the flat request buses and drive the one-hot ready vector.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
        assign op_arr[gi]    = req_op[gi*3 +: 3];
        assign req_ready[gi] = grant_fire && (grant_idx == ID_W'(gi));
    end

    // Round-robin search: the first valid requester after rr_ptr wins.
    // Walking the offsets downwards lets the nearest one overwrite the rest.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next state and grant permission; a new grant may overlap a response accept.
    always_comb begin
        state_next    = state_reg;
        grant_allowed = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_allowed = 1'b1;
                if (grant_any) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    grant_allowed = 1'b1;
                    state_next    = grant_any ? EXEC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_fire = grant_allowed & grant_any;

    // Latch the granted requester's operands and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= ID_W'(NUM_REQ - 1);
            opa_reg    <= '0;
            opb_reg    <= '0;
            opc_reg    <= '0;
            id_reg     <= '0;
        end else if (grant_fire) begin
            rr_ptr_reg <= grant_idx;
            opa_reg    <= a_arr[grant_idx];
            opb_reg    <= b_arr[grant_idx];
            opc_reg    <= op_arr[grant_idx];
            id_reg     <= grant_idx;
        end
    end

    // The shared fpu only ever sees the operand registers.
    fpu #(
        .WIDTH (WIDTH)
    ) u_fpu (
        .a  (opa_reg),
        .b  (opb_reg),
        .op (opc_reg),
        .y  (fpu_y)
    );

    // Capture the fpu result in EXEC and hold it until the response is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= id_reg;
            rsp_data_reg  <= fpu_y;
            rsp_err_reg   <= (opc_reg == 3'b111);
        end else if ((state_reg == RESP) && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // Count accepted responses; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count_reg <= '0;
        else if ((state_reg == RESP) && rsp_ready)
            op_count_reg <= op_count_reg + 16'd1;
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg != IDLE);
    assign op_count  = op_count_reg;
endmodule
